// File: rtl/mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module      : mem_access_unit
// Description : Pipeline memory stage. Accepts one load/store per handshake,
//               drives the d-cache with a held-request handshake, formats
//               byte/half/word stores into a line with a byte mask, extracts
//               and extends load data, flags misaligned/illegal requests as a
//               fault, and counts accesses that missed (saturating).
// Revision    : 1.0 - initial release
// ============================================================================
module mem_access_unit #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int LINE_WIDTH  = 128,
  parameter int OFFSET_BITS = $clog2(LINE_WIDTH / 8),
  parameter int CNT_WIDTH   = 16
) (
  input  logic                      clock,
  input  logic                      reset,
  // request side (from EX/MEM)
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic                      req_read,
  input  logic                      req_write,
  input  logic [1:0]                req_size,
  input  logic                      req_signed,
  input  logic [ADDR_WIDTH-1:0]     req_addr,
  input  logic [DATA_WIDTH-1:0]     req_wdata,
  // response side
  output logic                      resp_valid,
  output logic [DATA_WIDTH-1:0]     resp_data,
  output logic                      resp_fault,
  output logic                      stall,
  // data cache side
  output logic                      cache_enable,
  output logic                      cache_write,
  output logic [ADDR_WIDTH-1:0]     cache_addr,
  output logic [LINE_WIDTH-1:0]     cache_wline,
  output logic [LINE_WIDTH/8-1:0]   cache_wmask,
  input  logic [LINE_WIDTH-1:0]     cache_rline,
  input  logic                      cache_ready,
  input  logic                      cache_miss,
  // statistics
  output logic [CNT_WIDTH-1:0]      miss_count
);

  localparam int c_MASK_BITS = LINE_WIDTH / 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t                   r_state;
  state_t                   w_next_state;

  // latched request fields
  logic [ADDR_WIDTH-1:0]    r_addr;
  logic [1:0]               r_size;
  logic                     r_signed;
  logic                     r_write;
  logic [DATA_WIDTH-1:0]    r_wdata;
  logic                     r_fault;

  logic                     r_miss_flag;
  logic [DATA_WIDTH-1:0]    r_resp_data;
  logic [CNT_WIDTH-1:0]     r_miss_count;

  logic                     w_accept;
  logic                     w_misaligned;
  logic [OFFSET_BITS-1:0]   w_off;
  logic [OFFSET_BITS+2:0]   w_bit_off;
  logic [LINE_WIDTH-1:0]    w_store_ext;
  logic [c_MASK_BITS-1:0]   w_mask_base;
  logic [DATA_WIDTH-1:0]    w_rword;
  logic [DATA_WIDTH-1:0]    w_load_data;

  // A request is only taken when it names a direction; read+write together
  // is still taken so it can be reported as a fault.
  assign w_accept = (r_state == IDLE) && req_valid && (req_read || req_write);

  // Classify the incoming request as misaligned/illegal
  always_comb begin
    w_misaligned = 1'b0;
    case (req_size)
      2'b00:   w_misaligned = 1'b0;
      2'b01:   w_misaligned = req_addr[0];
      2'b10:   w_misaligned = |req_addr[1:0];
      default: w_misaligned = 1'b1;
    endcase
    if (req_read && req_write) begin
      w_misaligned = 1'b1;
    end
  end

  // State register
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic; DONE always lasts exactly one cycle
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_next_state = w_misaligned ? DONE : ACCESS;
        end
      end
      ACCESS: begin
        if (cache_ready) begin
          w_next_state = DONE;
        end
      end
      DONE:    w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // Request latch, sticky miss flag, load capture and miss counter
  always_ff @(posedge clock) begin
    if (reset) begin
      r_addr       <= '0;
      r_size       <= 2'b00;
      r_signed     <= 1'b0;
      r_write      <= 1'b0;
      r_wdata      <= '0;
      r_fault      <= 1'b0;
      r_miss_flag  <= 1'b0;
      r_resp_data  <= '0;
      r_miss_count <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_addr      <= req_addr;
            r_size      <= req_size;
            r_signed    <= req_signed;
            r_write     <= req_write && !req_read;
            r_wdata     <= req_wdata;
            r_fault     <= w_misaligned;
            r_miss_flag <= 1'b0;
            r_resp_data <= '0;
          end
        end
        ACCESS: begin
          if (cache_miss) begin
            r_miss_flag <= 1'b1;
          end
          if (cache_ready) begin
            r_resp_data <= r_write ? '0 : w_load_data;
            if ((r_miss_flag || cache_miss) && (r_miss_count != '1)) begin
              r_miss_count <= r_miss_count + CNT_WIDTH'(1);
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Byte offset within the line and the equivalent bit offset
  assign w_off     = r_addr[OFFSET_BITS-1:0];
  assign w_bit_off = {w_off, 3'b000};

  // Size-dependent store data (zero-extended) and unshifted byte mask
  always_comb begin
    w_store_ext = '0;
    w_mask_base = '0;
    case (r_size)
      2'b00: begin
        w_store_ext[7:0] = r_wdata[7:0];
        w_mask_base[0]   = 1'b1;
      end
      2'b01: begin
        w_store_ext[15:0] = r_wdata[15:0];
        w_mask_base[1:0]  = 2'b11;
      end
      default: begin
        w_store_ext[DATA_WIDTH-1:0] = r_wdata;
        w_mask_base[3:0]            = 4'hF;
      end
    endcase
  end

  // Natural alignment keeps every access inside one line, so a plain shift
  // of the line by the byte offset is enough for load extraction.
  assign w_rword = DATA_WIDTH'(cache_rline >> w_bit_off);

  // Truncate the selected element and extend it; words ignore req_signed
  always_comb begin
    w_load_data = w_rword;
    case (r_size)
      2'b00: begin
        w_load_data = r_signed ? {{(DATA_WIDTH-8){w_rword[7]}}, w_rword[7:0]}
                               : {{(DATA_WIDTH-8){1'b0}}, w_rword[7:0]};
      end
      2'b01: begin
        w_load_data = r_signed ? {{(DATA_WIDTH-16){w_rword[15]}}, w_rword[15:0]}
                               : {{(DATA_WIDTH-16){1'b0}}, w_rword[15:0]};
      end
      default: w_load_data = w_rword;
    endcase
  end

  assign req_ready    = (r_state == IDLE);
  assign stall        = (r_state != IDLE);
  assign resp_valid   = (r_state == DONE);
  assign resp_fault   = (r_state == DONE) && r_fault;
  assign resp_data    = (r_state == DONE) ? r_resp_data : '0;

  // Cache request fields come only from latched state, so they stay stable
  // for the whole time cache_enable is held.
  assign cache_enable = (r_state == ACCESS);
  assign cache_write  = r_write;
  assign cache_addr   = r_addr;
  assign cache_wline  = r_write ? (w_store_ext << w_bit_off) : '0;
  assign cache_wmask  = r_write ? (w_mask_base << w_off) : '0;

  assign miss_count   = r_miss_count;

endmodule
`default_nettype wire

// File: tb/tb_mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_access_unit
// Description : Self-checking bench for mem_access_unit. Table of load/store
//               vectors plus hand-written miss, saturation, reset-abort and
//               no-op sequences; responses checked through a scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_access_unit;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int LW = 128;
  localparam int MW = LW / 8;

  logic            clock = 1'b0;
  logic            reset = 1'b1;
  logic            req_valid, req_read, req_write, req_signed;
  logic [1:0]      req_size;
  logic [AW-1:0]   req_addr;
  logic [DW-1:0]   req_wdata;
  logic [LW-1:0]   cache_rline;
  logic            cache_ready, cache_miss;

  logic            req_ready, resp_valid, resp_fault, stall;
  logic [DW-1:0]   resp_data;
  logic            cache_enable, cache_write;
  logic [AW-1:0]   cache_addr;
  logic [LW-1:0]   cache_wline;
  logic [MW-1:0]   cache_wmask;
  logic [15:0]     miss_count;

  logic            s_req_ready, s_resp_valid, s_resp_fault, s_stall;
  logic [DW-1:0]   s_resp_data;
  logic            s_cache_enable, s_cache_write;
  logic [AW-1:0]   s_cache_addr;
  logic [LW-1:0]   s_cache_wline;
  logic [MW-1:0]   s_cache_wmask;
  logic [1:0]      s_miss_count;

  always #5 clock = ~clock;

  mem_access_unit #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LINE_WIDTH(LW), .CNT_WIDTH(16)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_read(req_read), .req_write(req_write),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_data(resp_data), .resp_fault(resp_fault), .stall(stall),
    .cache_enable(cache_enable), .cache_write(cache_write), .cache_addr(cache_addr),
    .cache_wline(cache_wline), .cache_wmask(cache_wmask), .cache_rline(cache_rline),
    .cache_ready(cache_ready), .cache_miss(cache_miss), .miss_count(miss_count)
  );

  // Narrow-counter instance: shares all stimulus, used to reach saturation quickly
  mem_access_unit #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LINE_WIDTH(LW), .CNT_WIDTH(2)) dut_sat (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(s_req_ready), .req_read(req_read), .req_write(req_write),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(s_resp_valid), .resp_data(s_resp_data), .resp_fault(s_resp_fault), .stall(s_stall),
    .cache_enable(s_cache_enable), .cache_write(s_cache_write), .cache_addr(s_cache_addr),
    .cache_wline(s_cache_wline), .cache_wmask(s_cache_wmask), .cache_rline(cache_rline),
    .cache_ready(cache_ready), .cache_miss(cache_miss), .miss_count(s_miss_count)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  typedef struct {
    logic [31:0] data;
    logic        fault;
  } resp_t;

  resp_t sb_q[$];
  resp_t mon_e;

  typedef struct {
    logic          rd;
    logic          wr;
    logic [1:0]    size;
    logic          sgn;
    logic [31:0]   addr;
    logic [31:0]   wdata;
    logic [127:0]  rline;
    logic [31:0]   exp_data;
    logic          exp_fault;
    logic [15:0]   exp_mask;
    logic [127:0]  exp_wline;
  } vec_t;

  localparam int NV = 15;
  vec_t vecs[NV];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    req_valid   = 1'b0;
    req_read    = 1'b0;
    req_write   = 1'b0;
    req_size    = 2'b00;
    req_signed  = 1'b0;
    req_addr    = '0;
    req_wdata   = '0;
    cache_rline = '0;
    cache_ready = 1'b0;
    cache_miss  = 1'b0;
  endtask

  // Response scoreboard: every resp_valid pulse must match the oldest expectation
  always @(negedge clock) begin
    if (resp_valid === 1'b1) begin
      if (sb_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_resp: got resp_valid=1 with data %0h, want no response", resp_data);
      end else begin
        mon_e = sb_q.pop_front();
        check("sb_resp_data", 128'(resp_data), 128'(mon_e.data));
        check("sb_resp_fault", 128'(resp_fault), 128'(mon_e.fault));
      end
    end
  end

  task automatic run_vec(input vec_t v, input int idx);
    req_valid  = 1'b1;
    req_read   = v.rd;
    req_write  = v.wr;
    req_size   = v.size;
    req_signed = v.sgn;
    req_addr   = v.addr;
    req_wdata  = v.wdata;
    check($sformatf("v%0d_req_ready", idx), 128'(req_ready), 128'(1));
    tick();                                   // accept edge N
    idle_inputs();
    sb_q.push_back('{v.exp_data, v.exp_fault});
    if (v.exp_fault) begin
      check($sformatf("v%0d_fault_resp_valid", idx), 128'(resp_valid), 128'(1));
      check($sformatf("v%0d_fault_enable", idx), 128'(cache_enable), 128'(0));
      tick();
      check($sformatf("v%0d_fault_idle", idx), 128'(req_ready), 128'(1));
      check($sformatf("v%0d_fault_enable2", idx), 128'(cache_enable), 128'(0));
    end else begin
      check($sformatf("v%0d_enable", idx), 128'(cache_enable), 128'(1));
      check($sformatf("v%0d_stall", idx), 128'(stall), 128'(1));
      check($sformatf("v%0d_cache_write", idx), 128'(cache_write), 128'(v.wr));
      check($sformatf("v%0d_cache_addr", idx), 128'(cache_addr), 128'(v.addr));
      check($sformatf("v%0d_wmask", idx), 128'(cache_wmask), 128'(v.exp_mask));
      check($sformatf("v%0d_wline", idx), cache_wline, v.exp_wline);
      check($sformatf("v%0d_no_early_resp", idx), 128'(resp_valid), 128'(0));
      cache_ready = 1'b1;
      cache_rline = v.rline;
      tick();                                 // N+2
      idle_inputs();
      check($sformatf("v%0d_resp_valid_n2", idx), 128'(resp_valid), 128'(1));
      check($sformatf("v%0d_enable_drop", idx), 128'(cache_enable), 128'(0));
      tick();
      check($sformatf("v%0d_resp_one_cycle", idx), 128'(resp_valid), 128'(0));
      check($sformatf("v%0d_ready_again", idx), 128'(req_ready), 128'(1));
    end
    check($sformatf("v%0d_miss_count", idx), 128'(miss_count), 128'(0));
  endtask

  // Word load that sees cache_miss for 5 ACCESS cycles, then completes
  task automatic miss_run(input logic [31:0] addr, input logic [127:0] rline, input logic [31:0] exp);
    req_valid = 1'b1;
    req_read  = 1'b1;
    req_size  = 2'b10;
    req_addr  = addr;
    tick();
    idle_inputs();
    sb_q.push_back('{exp, 1'b0});
    for (int c = 0; c < 5; c++) begin
      cache_miss = 1'b1;
      check("miss_stall", 128'(stall), 128'(1));
      check("miss_enable", 128'(cache_enable), 128'(1));
      check("miss_addr_stable", 128'(cache_addr), 128'(addr));
      tick();
    end
    cache_miss  = 1'b0;
    cache_ready = 1'b1;
    cache_rline = rline;
    check("miss_last_access_enable", 128'(cache_enable), 128'(1));
    check("miss_last_access_addr", 128'(cache_addr), 128'(addr));
    tick();
    idle_inputs();
    check("miss_done_stall", 128'(stall), 128'(1));
    check("miss_done_resp", 128'(resp_valid), 128'(1));
    tick();
    check("miss_idle_stall", 128'(stall), 128'(0));
  endtask

  initial begin
    // rline bytes 15..0: 9A BC 33 44 | 80 66 55 44 | 33 22 11 00 | AA BB CC DD
    vecs[0]  = '{1'b0, 1'b1, 2'b10, 1'b0, 32'h104, 32'hDEADBEEF, '1, 32'h0, 1'b0, 16'h00F0,
                 128'h00000000_00000000_DEADBEEF_00000000};
    vecs[1]  = '{1'b1, 1'b0, 2'b00, 1'b1, 32'h10B, 32'h0, 128'h9ABC3344_80665544_33221100_AABBCCDD,
                 32'hFFFFFF80, 1'b0, 16'h0, 128'h0};
    vecs[2]  = '{1'b1, 1'b0, 2'b00, 1'b0, 32'h10B, 32'h0, 128'h9ABC3344_80665544_33221100_AABBCCDD,
                 32'h00000080, 1'b0, 16'h0, 128'h0};
    vecs[3]  = '{1'b1, 1'b0, 2'b01, 1'b1, 32'h10E, 32'h0, 128'h9ABC3344_80665544_33221100_AABBCCDD,
                 32'hFFFF9ABC, 1'b0, 16'h0, 128'h0};
    vecs[4]  = '{1'b1, 1'b0, 2'b01, 1'b0, 32'h10E, 32'h0, 128'h9ABC3344_80665544_33221100_AABBCCDD,
                 32'h00009ABC, 1'b0, 16'h0, 128'h0};
    vecs[5]  = '{1'b1, 1'b0, 2'b10, 1'b1, 32'h108, 32'h0, 128'h9ABC3344_80665544_33221100_AABBCCDD,
                 32'h80665544, 1'b0, 16'h0, 128'h0};
    vecs[6]  = '{1'b0, 1'b1, 2'b00, 1'b0, 32'h10F, 32'h123456A5, '1, 32'h0, 1'b0, 16'h8000,
                 128'hA5000000_00000000_00000000_00000000};
    vecs[7]  = '{1'b0, 1'b1, 2'b01, 1'b0, 32'h102, 32'hFFFFBEEF, '1, 32'h0, 1'b0, 16'h000C,
                 128'h00000000_00000000_00000000_BEEF0000};
    vecs[8]  = '{1'b1, 1'b0, 2'b01, 1'b0, 32'h201, 32'h0, '1, 32'h0, 1'b1, 16'h0, 128'h0};
    vecs[9]  = '{1'b1, 1'b0, 2'b11, 1'b0, 32'h200, 32'h0, '1, 32'h0, 1'b1, 16'h0, 128'h0};
    vecs[10] = '{1'b0, 1'b1, 2'b10, 1'b0, 32'h202, 32'h11111111, '1, 32'h0, 1'b1, 16'h0, 128'h0};
    vecs[11] = '{1'b1, 1'b1, 2'b10, 1'b0, 32'h200, 32'h0, '1, 32'h0, 1'b1, 16'h0, 128'h0};
    vecs[12] = '{1'b1, 1'b0, 2'b00, 1'b0, 32'h100, 32'h0, 128'h9ABC3344_80665544_33221100_AABBCCDD,
                 32'h000000DD, 1'b0, 16'h0, 128'h0};
    vecs[13] = '{1'b1, 1'b0, 2'b00, 1'b1, 32'h101, 32'h0, 128'h9ABC3344_80665544_33221100_AABBCCDD,
                 32'hFFFFFFCC, 1'b0, 16'h0, 128'h0};
    vecs[14] = '{1'b1, 1'b0, 2'b01, 1'b1, 32'h104, 32'h0, 128'h9ABC3344_80665544_33221100_AABBCCDD,
                 32'h00001100, 1'b0, 16'h0, 128'h0};

    idle_inputs();
    reset = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    tick();

    // Reset state
    check("rst_req_ready", 128'(req_ready), 128'(1));
    check("rst_resp_valid", 128'(resp_valid), 128'(0));
    check("rst_resp_data", 128'(resp_data), 128'(0));
    check("rst_resp_fault", 128'(resp_fault), 128'(0));
    check("rst_stall", 128'(stall), 128'(0));
    check("rst_enable", 128'(cache_enable), 128'(0));
    check("rst_cache_write", 128'(cache_write), 128'(0));
    check("rst_cache_addr", 128'(cache_addr), 128'(0));
    check("rst_wline", cache_wline, 128'(0));
    check("rst_wmask", 128'(cache_wmask), 128'(0));
    check("rst_miss_count", 128'(miss_count), 128'(0));

    // Table-driven loads, stores and faults
    for (int i = 0; i < NV; i++) begin
      run_vec(vecs[i], i);
    end

    // Miss accounting and saturation (2-bit instance saturates at 3)
    miss_run(32'h300, 128'h0000_0000_0000_0000_0000_0000_CAFE_F00D, 32'hCAFEF00D);
    check("miss_count_1", 128'(miss_count), 128'(1));
    check("sat_count_1", 128'(s_miss_count), 128'(1));
    for (int k = 0; k < 4; k++) begin
      miss_run(32'h304, 128'h0000_0000_0000_0000_1234_5678_0000_0000, 32'h12345678);
    end
    check("miss_count_5", 128'(miss_count), 128'(5));
    check("sat_count_sat", 128'(s_miss_count), 128'(3));

    // Reset during the 3rd ACCESS cycle: no response, counter cleared
    req_valid = 1'b1;
    req_read  = 1'b1;
    req_size  = 2'b10;
    req_addr  = 32'h400;
    tick();
    idle_inputs();
    cache_miss = 1'b1;
    tick();
    tick();
    check("abort_in_access", 128'(cache_enable), 128'(1));
    reset = 1'b1;
    tick();
    check("abort_enable", 128'(cache_enable), 128'(0));
    check("abort_stall", 128'(stall), 128'(0));
    check("abort_resp_valid", 128'(resp_valid), 128'(0));
    check("abort_miss_count", 128'(miss_count), 128'(0));
    check("abort_sat_count", 128'(s_miss_count), 128'(0));
    reset      = 1'b0;
    cache_miss = 1'b0;
    tick();
    check("abort_idle_ready", 128'(req_ready), 128'(1));

    // No-op request plus stray cache_ready/cache_miss while idle
    req_valid   = 1'b1;
    cache_ready = 1'b1;
    cache_miss  = 1'b1;
    for (int k = 0; k < 2; k++) begin
      tick();
      check("noop_ready", 128'(req_ready), 128'(1));
      check("noop_enable", 128'(cache_enable), 128'(0));
      check("noop_stall", 128'(stall), 128'(0));
      check("noop_resp", 128'(resp_valid), 128'(0));
    end
    idle_inputs();
    tick();
    check("noop_miss_count", 128'(miss_count), 128'(0));

    // Clean load after the abort: sticky flag must have been cleared
    run_vec(vecs[5], 100);

    for (int k = 0; k < 10 && sb_q.size() > 0; k++) begin
      tick();
    end
    check("sb_drained", 128'(sb_q.size()), 128'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
